// File: rtl/ps2_pkg.sv
// Shared PS/2 frame definitions: state encoding, frame geometry and parity sense.
package ps2_pkg;

  localparam int   DATA_W     = 8;
  localparam int   FRAME_BITS = 11;   // start + 8 data + parity + stop
  localparam logic PARITY_ODD = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return (^{d, p}) == PARITY_ODD;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronizers for ps2c/ps2d, a run-length glitch filter on the clock
// and a falling-edge strobe of the filtered clock.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic level,
  output logic fall_tick,
  output logic data
);

  logic [1:0]            c_meta;
  logic [1:0]            d_meta;
  logic [FILTER_LEN-1:0] hist;
  logic                  level_q;

  // Everything resets to the idle-high bus level so release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_meta  <= '1;
      d_meta  <= '1;
      hist    <= '1;
      level   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      c_meta  <= {c_meta[0], ps2c};
      d_meta  <= {d_meta[0], ps2d};
      hist    <= {hist[FILTER_LEN-2:0], c_meta[1]};
      if (&hist)
        level <= 1'b1;
      else if (~|hist)
        level <= 1'b0;
      level_q <= level;
    end
  end

  assign fall_tick = level_q & ~level;
  assign data      = d_meta[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start/8 data LSB-first/odd parity/stop,
// with a mid-frame inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              ps2d,
  input  logic              ps2c,
  output logic              rx_done_tick,
  output logic [DATA_W-1:0] dout,
  output logic              frame_err_tick
);

  localparam int            TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam int            BW     = $clog2(DATA_W);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 4);

  logic clk_level, fall_tick, d_sync, fall;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .level     (clk_level),
    .fall_tick (fall_tick),
    .data      (d_sync)
  );

  // Sample only once the filtered clock has settled low.
  assign fall = fall_tick & ~clk_level;

  state_t            state, state_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [DATA_W-1:0] sr, sr_n, dout_n;
  logic              par, par_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              done_n, err_n, timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bcnt           <= '0;
      sr             <= '0;
      par            <= 1'b0;
      tcnt           <= '0;
      dout           <= '0;
      rx_done_tick   <= 1'b0;
      frame_err_tick <= 1'b0;
    end else begin
      state          <= state_n;
      bcnt           <= bcnt_n;
      sr             <= sr_n;
      par            <= par_n;
      tcnt           <= tcnt_n;
      dout           <= dout_n;
      rx_done_tick   <= done_n;
      frame_err_tick <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sr_n    = sr;
    par_n   = par;
    dout_n  = dout;
    done_n  = 1'b0;
    err_n   = 1'b0;
    timeout = 1'b0;
    tcnt_n  = '0;

    // A falling edge always wins over an expiring timeout.
    if (state != IDLE && !fall) begin
      if (tcnt == T_LAST)
        timeout = 1'b1;
      else
        tcnt_n = tcnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (fall && rx_en && !d_sync) begin
          state_n = DATA;
          bcnt_n  = '0;
        end
      end
      DATA: begin
        if (fall) begin
          sr_n   = {d_sync, sr[DATA_W-1:1]};
          bcnt_n = bcnt + 1'b1;
          if (bcnt == B_LAST)
            state_n = PAR;
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      PAR: begin
        if (fall) begin
          par_n   = d_sync;
          state_n = STOP;
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (d_sync && parity_ok(sr, par)) begin
            dout_n = sr;
            done_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed and randomized frames against a frame-level model of the PS/2 receiver.
module tb_ps2_frame_rx;
  import ps2_pkg::*;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_en = 1'b1;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       rx_done_tick, frame_err_tick;
  logic [7:0] dout;

  always #5 clk = ~clk;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_en          (rx_en),
    .ps2d           (ps2d),
    .ps2c           (ps2c),
    .rx_done_tick   (rx_done_tick),
    .dout           (dout),
    .frame_err_tick (frame_err_tick)
  );

  int pass_cnt = 0, total = 0, fail_cnt = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
  int fall_cnt = 0, last_fall_cyc = 0, err_cyc = 0;
  logic done_q = 1'b0, err_q = 1'b0;
  logic [7:0] model_dout = 8'h00;

  // Pulse bookkeeping sampled on the inactive edge.
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    done_q <= rx_done_tick;
    err_q  <= frame_err_tick;
    if (rx_done_tick) done_cnt <= done_cnt + 1;
    if (frame_err_tick) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (rx_done_tick && frame_err_tick) both_cnt <= both_cnt + 1;
    if ((rx_done_tick && done_q) || (frame_err_tick && err_q)) long_cnt <= long_cnt + 1;
    if (dut.u_filt.fall_tick) begin
      fall_cnt      <= fall_cnt + 1;
      last_fall_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bits go out index 0 first; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit drop_en);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      cycles(HALF);
      ps2c = 1'b0;
      cycles(HALF);
      ps2c = 1'b1;
      if (drop_en && i == 0) rx_en = 1'b0;
    end
    ps2d = 1'b1;
    cycles(HALF);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit stop);
    logic p;
    p = ~(^d) ^ bad_par;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                           input bit en, input bit drop, input string tag);
    logic [10:0] bits;
    int d0, e0;
    bit ok;
    bits = frame_bits(d, bad_par, stop);
    d0 = done_cnt;
    e0 = err_cnt;
    rx_en = en;
    send_bits(bits, 11, drop);
    cycles(20);
    rx_en = 1'b1;
    ok = en && stop && ($countones(bits[9:1]) % 2 == 1);
    if (ok) model_dout = d;
    check({tag, "_done"}, done_cnt - d0, {31'b0, ok});
    check({tag, "_err"}, err_cnt - e0, {31'b0, en && !ok});
    check({tag, "_dout"}, {24'b0, dout}, {24'b0, model_dout});
  endtask

  initial begin
    int d0, e0, f0, lat;
    logic [7:0] rd;
    int kind;

    // Reset state
    cycles(5);
    check("rst_dout", {24'b0, dout}, 32'h0);
    check("rst_done", {31'b0, rx_done_tick}, 32'h0);
    check("rst_err", {31'b0, frame_err_tick}, 32'h0);
    reset = 1'b0;
    cycles(30);
    check("rel_state", {30'b0, dut.state}, {30'b0, IDLE});
    check("rel_nofall", fall_cnt, 0);

    // Basic and back-to-back frames, then a bad-parity frame
    run_frame(8'h1C, 0, 1, 1, 0, "f1c");
    run_frame(8'hF0, 0, 1, 1, 0, "bb_f0");
    run_frame(8'h1C, 0, 1, 1, 0, "bb_1c");
    run_frame(8'h1C, 1, 1, 1, 0, "badpar");

    // 3-cycle glitch on idle clock
    f0 = fall_cnt; d0 = done_cnt; e0 = err_cnt;
    ps2c = 1'b0;
    cycles(3);
    ps2c = 1'b1;
    cycles(40);
    check("gl_fall", fall_cnt - f0, 0);
    check("gl_state", {30'b0, dut.state}, {30'b0, IDLE});
    check("gl_ticks", (done_cnt - d0) + (err_cnt - e0), 0);

    // Truncated frame: start + 4 data bits, then silence
    d0 = done_cnt; e0 = err_cnt;
    send_bits(frame_bits(8'h1C, 0, 1), 5, 0);
    for (int k = 0; k < 3 * TO && err_cnt == e0; k++) cycles(1);
    cycles(3);
    lat = err_cyc - last_fall_cyc;
    check("to_err", err_cnt - e0, 1);
    check("to_done", done_cnt - d0, 0);
    check("to_lat_ok", {31'b0, (lat == TO || lat == TO + 1)}, 32'h1);
    check("to_state", {30'b0, dut.state}, {30'b0, IDLE});
    run_frame(8'h1C, 0, 1, 1, 0, "after_to");

    // Reset mid-frame after 5 data bits
    send_bits(frame_bits(8'h55, 0, 1), 6, 0);
    d0 = done_cnt; e0 = err_cnt;
    reset = 1'b1;
    cycles(5);
    check("mr_done", done_cnt - d0, 0);
    check("mr_err", err_cnt - e0, 0);
    check("mr_dout", {24'b0, dout}, 32'h0);
    reset = 1'b0;
    model_dout = 8'h00;
    cycles(20);
    run_frame(8'hF0, 0, 1, 1, 0, "mr_f0");

    // Randomized frames: good, bad parity, bad stop, disabled, enable dropped mid-frame
    for (int n = 0; n < 12; n++) begin
      rd   = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 5);
      run_frame(rd, kind == 0, kind != 1, kind != 2, kind == 3, "rnd");
    end

    check("excl", both_cnt, 0);
    check("single", long_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
